io_terminal_adapter: RTL and testbench
======================================

IO_TERMINAL_ADAPTER -- requirements
Module: io_terminal_adapter

Interface
REQ-001 Parameter RX_DEPTH, default 4, SHALL set the input FIFO depth in bytes; it is a power of two and at least 2.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_data  input  8  SHALL carry the keyboard byte from the external source.
REQ-005 in_valid  input  1  SHALL indicate that in_data is valid.
REQ-006 in_ready  output  1  SHALL indicate that the adapter accepts in_data this cycle.
REQ-007 out_data  output  8  SHALL carry the printer byte to the external sink.
REQ-008 out_valid  output  1  SHALL indicate that out_data is valid.
REQ-009 out_ready  input  1  SHALL indicate that the sink accepts out_data this cycle.
REQ-010 INPR_in  output  8  SHALL be the byte presented to the computer's INPR.
REQ-011 set_FGI  output  1  SHALL set the computer's FGI flag.
REQ-012 FGI_out  input  1  SHALL be the current FGI flag.
REQ-013 OUTR_out  input  8  SHALL be the computer's OUTR contents.
REQ-014 FGO_out  input  1  SHALL be the current FGO flag.
REQ-015 set_FGO  output  1  SHALL set the computer's FGO flag.

Function
REQ-016 Input FIFO: push when in_valid&&in_ready; in_ready SHALL be 1 exactly when the occupancy is below RX_DEPTH.
- Pointers wrap modulo RX_DEPTH.
- Occupancy counter is $clog2(RX_DEPTH)+1 bits.
REQ-017 A push to an empty FIFO SHALL NOT bypass it; the byte becomes poppable the cycle after the push.
REQ-018 Push and pop in the same cycle SHALL leave the occupancy unchanged; a push when full is impossible because in_ready=0.
REQ-019 Input FSM SHALL use states IN_IDLE, IN_SET, IN_WAIT and IN_BUSY.
- IN_IDLE: if the FIFO is non-empty and FGI_out==0, pop the head into the INPR_in register and go to IN_SET.
- IN_SET: set_FGI=1 for exactly one cycle; go to IN_WAIT.
- IN_WAIT: when FGI_out==1, go to IN_BUSY.
- IN_BUSY: when FGI_out==0 (INP executed), go to IN_IDLE.
REQ-020 INPR_in SHALL hold its value from the pop until the next pop.
- Latency: push at edge N, pop at N+1, INPR_in updated at N+1.
- set_FGI is high during the cycle N+1..N+2.
REQ-021 Output FSM SHALL use states O_SET, O_WAIT, O_IDLE and O_SEND.
- O_SET: set_FGO=1 for exactly one cycle; go to O_WAIT.
- O_WAIT: when FGO_out==1, go to O_IDLE.
- O_IDLE: when FGO_out==0 (OUT executed; OUTR loads on the same edge), capture OUTR_out into out_data, assert out_valid, and go to O_SEND.
- O_SEND: hold out_data and out_valid until out_valid&&out_ready; then clear out_valid and go to O_SET.
REQ-022 out_data SHALL remain stable while out_valid=1; out_valid SHALL NOT drop without a handshake.
REQ-023 The input and output paths SHALL operate independently; simultaneous activity on both SHALL NOT stall either.
REQ-024 set_FGI and set_FGO SHALL be registered outputs.

Reset
REQ-025 While rst_n=0, the adapter SHALL drive in_ready=0, out_valid=0, out_data=0, INPR_in=0, set_FGI=0 and set_FGO=0, and SHALL empty the FIFO.
REQ-026 Reset SHALL place the input FSM in IN_IDLE and the output FSM in O_SET.
- The first cycle after release therefore pulses set_FGO with no byte emitted.
REQ-027 Reset asserted mid-transfer SHALL discard the queued bytes and any pending out_data without issuing a handshake.
REQ-028 in_ready SHALL assert in the first cycle after rst_n rises.

Structure
REQ-029 Package basic_comp_io_pkg SHALL hold the in_state_t and out_state_t enums and the constant BYTE_W=8.
REQ-030 The FIFO SHALL be a sub-module io_fifo (parameters WIDTH and DEPTH) with push, pop, full, empty and head outputs.

Verification
REQ-031 Scenario: reset release with FGO_out model -> set_FGO pulses exactly once in cycle 1; out_valid stays 0.
REQ-032 Scenario: push 0x41 with FGI_out=0 -> INPR_in=0x41 and a 1-cycle set_FGI one edge after the push; no second pop until FGI goes 1 then 0.
REQ-033 Scenario: push 5 bytes 0x01..0x05 back-to-back with FGI held 1 (RX_DEPTH=4) -> in_ready drops after the 4th push; 0x05 accepted once the first pop occurs; bytes delivered in order.
REQ-034 Scenario: OUTR_out=0x5A with FGO_out falling, out_ready=0 for 3 cycles -> out_data=0x5A stable with out_valid=1; after the handshake, set_FGO pulses once.
REQ-035 Scenario: concurrent push 0x33 and FGO fall with OUTR=0x77 -> INPR_in=0x33 with set_FGI, and out_data=0x77 with out_valid, in the same cycles as in isolation.
REQ-036 Scenario: assert rst_n=0 during O_SEND with 2 bytes queued -> out_valid=0 immediately, FIFO empty, no handshake, and set_FGO pulses after release.

Source files
------------

// File: rtl/basic_comp_io_pkg.sv
// Shared types for the basic-computer terminal adapter: byte width and the
// state encodings of the keyboard (input) and printer (output) handshakes.
package basic_comp_io_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_SET  = 2'd1,
    IN_WAIT = 2'd2,
    IN_BUSY = 2'd3
  } in_state_t;

  typedef enum logic [1:0] {
    O_SET  = 2'd0,
    O_WAIT = 2'd1,
    O_IDLE = 2'd2,
    O_SEND = 2'd3
  } out_state_t;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO with registered storage; the head entry is visible
// combinationally and becomes valid the cycle after it is pushed.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_terminal_adapter.sv
// Bridges a byte stream to the basic computer's INPR/FGI keyboard flags and
// OUTR/FGO printer flags; the two directions run fully independently.
module io_terminal_adapter
  import basic_comp_io_pkg::*;
#(
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // valid/ready: a byte moves on an edge where valid and ready are both 1;
  // the sender holds valid and data stable until that edge.
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] INPR_in,
  output logic              set_FGI,
  input  logic              FGI_out,
  input  logic [BYTE_W-1:0] OUTR_out,
  input  logic              FGO_out,
  output logic              set_FGO,
  output logic [1:0]        in_state_dbg,
  output logic [1:0]        out_state_dbg
);

  in_state_t         in_state;
  out_state_t        out_state;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;
  logic              push;
  logic              pop;

  // Gating with rst_n keeps in_ready low throughout reset, high right after.
  assign in_ready      = rst_n && !fifo_full;
  assign push          = in_valid && in_ready;
  assign pop           = (in_state == IN_IDLE) && !fifo_empty && !FGI_out;
  assign in_state_dbg  = in_state;
  assign out_state_dbg = out_state;

  io_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Keyboard side: one byte per INP, gated by FGI completing a 1 -> 0 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state <= IN_IDLE;
      INPR_in  <= '0;
      set_FGI  <= 1'b0;
    end else begin
      set_FGI <= 1'b0;
      case (in_state)
        IN_IDLE: begin
          if (pop) begin
            INPR_in  <= fifo_head;
            set_FGI  <= 1'b1;
            in_state <= IN_SET;
          end
        end
        IN_SET:  in_state <= IN_WAIT;
        IN_WAIT: if (FGI_out)  in_state <= IN_BUSY;
        IN_BUSY: if (!FGI_out) in_state <= IN_IDLE;
        default: in_state <= IN_IDLE;
      endcase
    end
  end

  // Printer side: raise FGO, wait for the OUT that clears it, then forward OUTR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= O_SET;
      out_data  <= '0;
      out_valid <= 1'b0;
      set_FGO   <= 1'b0;
    end else begin
      set_FGO <= 1'b0;
      case (out_state)
        O_SET: begin
          set_FGO   <= 1'b1;
          out_state <= O_WAIT;
        end
        O_WAIT: if (FGO_out) out_state <= O_IDLE;
        O_IDLE: begin
          if (!FGO_out) begin
            out_data  <= OUTR_out;
            out_valid <= 1'b1;
            out_state <= O_SEND;
          end
        end
        O_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_state <= O_SET;
          end
        end
        default: out_state <= O_SET;
      endcase
    end
  end

endmodule

// File: tb/tb_io_terminal_adapter.sv
// Bench for io_terminal_adapter: a behavioural model of the computer's FGI/FGO
// flags plus queue-based expectations for the keyboard and printer byte streams.
module tb_io_terminal_adapter;
  import basic_comp_io_pkg::*;

  localparam int RX_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] INPR_in;
  logic       set_FGI;
  logic       fgi = 1'b0;
  logic [7:0] outr = '0;
  logic       fgo = 1'b0;
  logic       set_FGO;
  logic [1:0] in_state_dbg;
  logic [1:0] out_state_dbg;

  io_terminal_adapter #(.RX_DEPTH(RX_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .INPR_in       (INPR_in),
    .set_FGI       (set_FGI),
    .FGI_out       (fgi),
    .OUTR_out      (outr),
    .FGO_out       (fgo),
    .set_FGO       (set_FGO),
    .in_state_dbg  (in_state_dbg),
    .out_state_dbg (out_state_dbg)
  );

  // ---------------- model state / scoreboard ----------------
  logic [7:0] exp_in_q[$];
  logic [7:0] exp_out_q[$];
  int pushes = 0;
  int pops = 0;
  int fgo_exp = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic inp_req = 1'b0, out_req = 1'b0, inp_auto = 1'b0, out_auto = 1'b0;
  logic [7:0] out_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Computer flags: set_* raises the flag on an edge; INP/OUT clear it.
  initial forever begin
    logic s_fgi, s_fgo, do_inp, do_out;
    logic [7:0] v;
    @(negedge clk);
    s_fgi  = set_FGI;
    s_fgo  = set_FGO;
    do_inp = fgi && (inp_req || (inp_auto && $urandom_range(0, 2) == 0));
    do_out = fgo && (out_req || (out_auto && $urandom_range(0, 2) == 0));
    v      = out_auto ? 8'($urandom) : out_val;
    @(posedge clk);
    #1;
    if (s_fgi) fgi = 1'b1;
    else if (do_inp) fgi = 1'b0;
    if (s_fgo) fgo = 1'b1;
    else if (do_out) begin
      fgo  = 1'b0;
      outr = v;
      if (rst_n) exp_out_q.push_back(v);
    end
  end

  // Monitor: checks every cycle at the falling edge.
  initial forever begin
    logic p_sfgi, p_sfgo, p_ov, p_hs;
    logic [7:0] p_inpr, p_od;
    @(negedge clk);
    if (!rst_n) begin
      p_sfgi = 0; p_sfgo = 0; p_ov = 0; p_hs = 0; p_inpr = 0; p_od = 0;
    end else begin
      if (set_FGI && !p_sfgi) begin
        pops++;
        chk("pop_only_when_fgi_clear", fgi, 0);
        if (exp_in_q.size() == 0) chk("unexpected_pop_inpr", INPR_in, 32'hFFFF_FFFF);
        else chk("inpr_data", INPR_in, exp_in_q.pop_front());
      end else begin
        chk("inpr_hold", INPR_in, p_inpr);
      end
      chk("set_fgi_width", set_FGI && p_sfgi, 0);
      chk("in_ready_occupancy", in_ready, (pushes - pops) < RX_DEPTH);
      if (in_valid && in_ready) begin
        exp_in_q.push_back(in_data);
        pushes++;
      end
      if (set_FGO && !p_sfgo) begin
        chk("set_fgo_expected", fgo_exp > 0, 1);
        if (fgo_exp > 0) fgo_exp--;
      end
      chk("set_fgo_width", set_FGO && p_sfgo, 0);
      if (p_ov && !p_hs) begin
        chk("out_valid_hold", out_valid, 1);
        chk("out_data_hold", out_data, p_od);
      end else if (out_valid) begin
        if (exp_out_q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
        else chk("out_data", out_data, exp_out_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_out_q.size() > 0) void'(exp_out_q.pop_front());
        fgo_exp++;
      end
      p_sfgi = set_FGI; p_sfgo = set_FGO; p_ov = out_valid;
      p_hs = out_valid && out_ready; p_inpr = INPR_in; p_od = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_inpr"}, INPR_in, 0);
    chk({tag, "_set_fgi"}, set_FGI, 0);
    chk({tag, "_set_fgo"}, set_FGO, 0);
    chk({tag, "_in_state"}, in_state_dbg, IN_IDLE);
    chk({tag, "_out_state"}, out_state_dbg, O_SET);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inp_auto = 0; out_auto = 0;
    exp_in_q.delete(); exp_out_q.delete();
    pushes = 0; pops = 0; fgo_exp = 0;
    #1 check_reset_outputs("rst_immediate");
    repeat (cycles) begin
      @(negedge clk);
      check_reset_outputs("rst_hold");
    end
    @(negedge clk);
    #2;
    fgo_exp = 1;
    rst_n = 1'b1;
    #1 chk("in_ready_after_release", in_ready, 1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = b;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    chk("push_accepted", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_inp();
    @(posedge clk);
    #1 inp_req = 1'b1;
    @(posedge clk);
    #1 inp_req = 1'b0;
  endtask

  task automatic do_out(input logic [7:0] v);
    @(posedge clk);
    #1;
    out_val = v; out_req = 1'b1;
    @(posedge clk);
    #1 out_req = 1'b0;
  endtask

  task automatic wait_sig(input string name, input int which, input logic level, input int max_cyc);
    int t;
    logic s;
    t = 0;
    do begin
      @(negedge clk);
      case (which)
        0: s = set_FGI;
        1: s = out_valid;
        2: s = fgi;
        default: s = fgo;
      endcase
      t++;
    end while (s !== level && t < max_cyc);
    chk(name, s, level);
  endtask

  task automatic wait_inp_done();
    wait_sig("inp_done_fgi_high", 2, 1'b1, 50);
    wait_sig("inp_done_fgi_low", 2, 1'b0, 50);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    // Reset release: set_FGO pulses once in cycle 1, nothing emitted.
    do_reset(3);
    @(negedge clk);
    chk("rel_set_fgo_cycle1", set_FGO, 1);
    chk("rel_out_valid", out_valid, 0);
    @(negedge clk);
    chk("rel_set_fgo_cycle2", set_FGO, 0);
    repeat (4) begin
      @(negedge clk);
      chk("rel_no_output", out_valid, 0);
    end

    // Single keyboard byte: INPR and set_FGI one edge after the push edge.
    push_byte(8'h41);
    @(negedge clk);
    chk("kb_set_fgi_early", set_FGI, 0);
    @(negedge clk);
    chk("kb_set_fgi", set_FGI, 1);
    chk("kb_inpr", INPR_in, 8'h41);
    @(negedge clk);
    chk("kb_set_fgi_one_cycle", set_FGI, 0);
    push_byte(8'h42);
    repeat (5) begin
      @(negedge clk);
      chk("kb_no_second_pop", set_FGI, 0);
    end
    do_inp();
    wait_sig("kb_second_pop", 0, 1'b1, 10);
    chk("kb_inpr_second", INPR_in, 8'h42);

    // FGI held high: fill to depth, fifth byte waits for the first pop.
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      @(negedge clk);
      chk("fill_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_data = 8'h05;
    repeat (3) begin
      @(negedge clk);
      chk("full_not_ready", in_ready, 0);
    end
    do_inp();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 10);
    chk("ready_after_pop", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    inp_auto = 1'b1;
    t = 0;
    while (exp_in_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("fill_drained", exp_in_q.size(), 0);
    wait_inp_done();
    inp_auto = 1'b0;

    // Printer byte with back-pressure, then one set_FGO after the handshake.
    do_out(8'h5A);
    wait_sig("pr_valid", 1, 1'b1, 10);
    chk("pr_data", out_data, 8'h5A);
    repeat (3) begin
      @(negedge clk);
      chk("pr_stall_valid", out_valid, 1);
      chk("pr_stall_data", out_data, 8'h5A);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("pr_valid_cleared", out_valid, 0);
    chk("pr_set_fgo_early", set_FGO, 0);
    @(negedge clk);
    chk("pr_set_fgo_pulse", set_FGO, 1);
    wait_sig("pr_fgo_set", 3, 1'b1, 10);

    // Both directions in the same cycle keep their isolated timing.
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 8'h33; out_val = 8'h77; out_req = 1'b1;
    @(negedge clk);
    chk("cc_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_req = 1'b0;
    @(negedge clk);
    chk("cc_set_fgi_early", set_FGI, 0);
    chk("cc_out_valid_early", out_valid, 0);
    @(negedge clk);
    chk("cc_set_fgi", set_FGI, 1);
    chk("cc_inpr", INPR_in, 8'h33);
    chk("cc_out_valid", out_valid, 1);
    chk("cc_out_data", out_data, 8'h77);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    wait_sig("cc_fgo_set", 3, 1'b1, 10);

    // Reset in O_SEND with two bytes queued: everything discarded.
    push_byte(8'hA1);
    push_byte(8'hA2);
    do_out(8'h99);
    wait_sig("rs_valid", 1, 1'b1, 10);
    do_reset(2);
    @(negedge clk);
    chk("rs_set_fgo_after", set_FGO, 1);
    chk("rs_out_valid_after", out_valid, 0);
    do_inp();
    repeat (6) begin
      @(negedge clk);
      chk("rs_fifo_empty_no_pop", set_FGI, 0);
      chk("rs_out_valid_low", out_valid, 0);
    end

    // Randomised traffic on both paths.
    inp_auto = 1'b1; out_auto = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      logic hs;
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || hs) begin
        in_valid = ($urandom_range(0, 1) == 1);
        in_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    t = 0;
    while (in_valid && t < 50) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
      t++;
    end
    chk("rnd_last_push", in_valid, 0);
    out_auto = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    t = 0;
    while ((exp_in_q.size() != 0 || exp_out_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    chk("rnd_in_drained", exp_in_q.size(), 0);
    chk("rnd_out_drained", exp_out_q.size(), 0);
    chk("rnd_fgo_pulses_done", fgo_exp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
